// File: rtl/snake_body.sv
`default_nettype none
// ============================================================================
// Module   : snake_body
// Purpose  : Snake segment store, movement/growth/self-collision and pixel hit test.
// Revision : 1.0 - initial release
// ============================================================================
module snake_body #(
  parameter int SIZE    = 25,
  parameter int BIT     = 10,
  parameter int GRID_W  = 25,
  parameter int GRID_H  = 19,
  parameter int MAX_LEN = 8,
  parameter int LW      = 4,
  parameter int X_START = 300,
  parameter int Y_START = 300
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic [2:0]     direction,
  input  logic           grow,
  input  logic           restart,
  input  logic [BIT-1:0] x_pos,
  input  logic [BIT-1:0] y_pos,
  output logic           snake_head_active,
  output logic           snake_body_active,
  output logic           collision,
  output logic [LW-1:0]  length,
  output logic [2:0]     rgb
);

  localparam logic [1:0]     c_dir_up    = 2'b00;
  localparam logic [1:0]     c_dir_down  = 2'b01;
  localparam logic [1:0]     c_dir_left  = 2'b10;
  localparam logic [1:0]     c_dir_right = 2'b11;
  localparam logic [BIT-1:0] c_size      = BIT'(SIZE);
  localparam logic [BIT-1:0] c_x_max     = BIT'((GRID_W - 1) * SIZE);
  localparam logic [BIT-1:0] c_y_max     = BIT'((GRID_H - 1) * SIZE);
  localparam logic [BIT-1:0] c_x_start   = BIT'(X_START);
  localparam logic [BIT-1:0] c_y_start   = BIT'(Y_START);
  localparam logic [BIT:0]   c_size_ext  = (BIT + 1)'(SIZE);
  localparam logic [LW-1:0]  c_one       = LW'(1);
  localparam logic [LW-1:0]  c_max_len   = LW'(MAX_LEN);

  logic [BIT-1:0]     r_seg_x [MAX_LEN];
  logic [BIT-1:0]     r_seg_y [MAX_LEN];
  logic [1:0]         r_cur_dir;
  logic [LW-1:0]      r_len;
  logic               r_collision;
  logic               r_grow_pend;
  logic               r_moved;

  logic               w_step;
  logic               w_grow_now;
  logic               w_dir_ok;
  logic [1:0]         w_next_dir;
  logic [BIT-1:0]     w_head_x;
  logic [BIT-1:0]     w_head_y;
  logic [MAX_LEN-1:0] w_in_cell;
  logic [MAX_LEN-1:0] w_live;
  logic [MAX_LEN-1:0] w_hit;

  assign w_step     = tick & ~r_collision;
  assign w_grow_now = grow | r_grow_pend;
  // Reversing onto the neck is only illegal once there is a neck.
  assign w_dir_ok   = ~direction[2] &&
                      !((r_len > c_one) && (direction[1:0] == (r_cur_dir ^ 2'b01)));
  assign w_next_dir = w_dir_ok ? direction[1:0] : r_cur_dir;

  always_comb begin
    w_head_x = r_seg_x[0];
    w_head_y = r_seg_y[0];
    case (w_next_dir)
      c_dir_up:   w_head_y = (r_seg_y[0] == '0)      ? c_y_max : r_seg_y[0] - c_size;
      c_dir_down: w_head_y = (r_seg_y[0] == c_y_max) ? '0      : r_seg_y[0] + c_size;
      c_dir_left: w_head_x = (r_seg_x[0] == '0)      ? c_x_max : r_seg_x[0] - c_size;
      default:    w_head_x = (r_seg_x[0] == c_x_max) ? '0      : r_seg_x[0] + c_size;
    endcase
  end

  generate
    for (genvar i = 0; i < MAX_LEN; i++) begin : g_seg
      localparam logic [LW-1:0] c_idx = LW'(i);

      assign w_in_cell[i] = ({1'b0, x_pos} >= {1'b0, r_seg_x[i]}) &&
                            ({1'b0, x_pos} <  {1'b0, r_seg_x[i]} + c_size_ext) &&
                            ({1'b0, y_pos} >= {1'b0, r_seg_y[i]}) &&
                            ({1'b0, y_pos} <  {1'b0, r_seg_y[i]} + c_size_ext);
      assign w_live[i] = (c_idx < r_len);

      if (i == 0) begin : g_head
        assign w_hit[i] = 1'b0;
      end else begin : g_tail
        assign w_hit[i] = w_live[i] && (r_seg_x[i] == r_seg_x[0]) && (r_seg_y[i] == r_seg_y[0]);
      end
    end
  endgenerate

  assign snake_head_active = w_in_cell[0];
  assign snake_body_active = |(w_in_cell[MAX_LEN-1:1] & w_live[MAX_LEN-1:1]);
  assign collision         = r_collision;
  assign length            = r_len;
  assign rgb               = r_collision ? 3'b100 : 3'b010;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        r_seg_x[k] <= c_x_start;
        r_seg_y[k] <= c_y_start;
      end
      r_cur_dir   <= c_dir_right;
      r_len       <= c_one;
      r_collision <= 1'b0;
      r_grow_pend <= 1'b0;
      r_moved     <= 1'b0;
    end else if (restart) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        r_seg_x[k] <= c_x_start;
        r_seg_y[k] <= c_y_start;
      end
      r_cur_dir   <= c_dir_right;
      r_len       <= c_one;
      r_collision <= 1'b0;
      r_grow_pend <= 1'b0;
      r_moved     <= 1'b0;
    end else begin
      // Self-hit is judged on the positions settled by the previous move.
      r_moved <= w_step;
      if (r_moved && (|w_hit)) begin
        r_collision <= 1'b1;
      end
      if (w_step) begin
        r_cur_dir  <= w_next_dir;
        r_seg_x[0] <= w_head_x;
        r_seg_y[0] <= w_head_y;
        for (int k = 1; k < MAX_LEN; k++) begin
          r_seg_x[k] <= r_seg_x[k-1];
          r_seg_y[k] <= r_seg_y[k-1];
        end
        r_grow_pend <= 1'b0;
        if (w_grow_now && (r_len < c_max_len)) begin
          r_len <= r_len + c_one;
        end
      end else if (grow) begin
        r_grow_pend <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snake_body.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_body
// Purpose  : Scoreboard bench for snake_body against a queue-based snake model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_body;

  localparam int SIZE    = 25;
  localparam int BIT     = 10;
  localparam int GRID_W  = 25;
  localparam int GRID_H  = 19;
  localparam int MAX_LEN = 8;
  localparam int LW      = 4;
  localparam int X_START = 300;
  localparam int Y_START = 300;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b0;
  logic           tick      = 1'b0;
  logic [2:0]     direction = 3'b011;
  logic           grow      = 1'b0;
  logic           restart   = 1'b0;
  logic [BIT-1:0] x_pos     = '0;
  logic [BIT-1:0] y_pos     = '0;
  logic           snake_head_active;
  logic           snake_body_active;
  logic           collision;
  logic [LW-1:0]  length;
  logic [2:0]     rgb;

  int    n_checks = 0;
  int    n_errors = 0;
  string sb_tag[$];
  int    sb_exp[$];

  // Model keeps only the live segments, head first.
  int m_x[$];
  int m_y[$];
  int m_dir;
  bit m_pend;
  bit m_coll;

  snake_body #(
    .SIZE(SIZE), .BIT(BIT), .GRID_W(GRID_W), .GRID_H(GRID_H),
    .MAX_LEN(MAX_LEN), .LW(LW), .X_START(X_START), .Y_START(Y_START)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .direction(direction),
    .grow(grow), .restart(restart), .x_pos(x_pos), .y_pos(y_pos),
    .snake_head_active(snake_head_active), .snake_body_active(snake_body_active),
    .collision(collision), .length(length), .rgb(rgb)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int exp);
    sb_tag.push_back(tag);
    sb_exp.push_back(exp);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    string t;
    int    e;
    t = sb_tag.pop_front();
    e = sb_exp.pop_front();
    check_eq(t, obs, e);
  endtask

  function automatic void model_reset();
    m_x.delete();
    m_y.delete();
    m_x.push_back(X_START);
    m_y.push_back(Y_START);
    m_dir  = 3;
    m_pend = 1'b0;
    m_coll = 1'b0;
  endfunction

  function automatic void model_tick(input int d, input bit g);
    int nx;
    int ny;
    bit grow_now;
    if (m_coll) begin
      if (g) m_pend = 1'b1;
      return;
    end
    grow_now = m_pend | g;
    m_pend   = 1'b0;
    if (d < 4 && !(m_x.size() > 1 && (d ^ 1) == m_dir)) m_dir = d;
    nx = m_x[0];
    ny = m_y[0];
    case (m_dir)
      0:       ny = (ny == 0) ? (GRID_H - 1) * SIZE : ny - SIZE;
      1:       ny = (ny == (GRID_H - 1) * SIZE) ? 0 : ny + SIZE;
      2:       nx = (nx == 0) ? (GRID_W - 1) * SIZE : nx - SIZE;
      default: nx = (nx == (GRID_W - 1) * SIZE) ? 0 : nx + SIZE;
    endcase
    m_x.push_front(nx);
    m_y.push_front(ny);
    if (!(grow_now && m_x.size() <= MAX_LEN)) begin
      void'(m_x.pop_back());
      void'(m_y.pop_back());
    end
    for (int i = 1; i < m_x.size(); i++) begin
      if (m_x[i] == nx && m_y[i] == ny) m_coll = 1'b1;
    end
  endfunction

  function automatic bit inside_cell(input int ox, input int oy, input int px, input int py);
    return (px >= ox) && (px < ox + SIZE) && (py >= oy) && (py < oy + SIZE);
  endfunction

  task automatic probe(input int px, input int py, input string tag);
    bit eb;
    eb = 1'b0;
    for (int i = 1; i < m_x.size(); i++) begin
      if (inside_cell(m_x[i], m_y[i], px, py)) eb = 1'b1;
    end
    @(negedge clk);
    x_pos = px[BIT-1:0];
    y_pos = py[BIT-1:0];
    sb_push({tag, "_head"}, int'(inside_cell(m_x[0], m_y[0], px, py)));
    sb_push({tag, "_body"}, int'(eb));
    #1;
    sb_pop(snake_head_active);
    sb_pop(snake_body_active);
  endtask

  task automatic check_head(input string tag);
    probe(m_x[0], m_y[0], {tag, "_org"});
    probe(m_x[0] + SIZE - 1, m_y[0] + SIZE - 1, {tag, "_far"});
    probe(m_x[0] + SIZE, m_y[0], {tag, "_out"});
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    sb_push({tag, "_len"}, m_x.size());
    sb_push({tag, "_coll"}, int'(m_coll));
    sb_push({tag, "_rgb"}, m_coll ? 4 : 2);
    #1;
    sb_pop(length);
    sb_pop(collision);
    sb_pop(rgb);
  endtask

  // Two edges per move: one executes the tick, one lets the self-hit register.
  task automatic step(input int d, input bit g);
    @(negedge clk);
    direction = d[2:0];
    tick      = 1'b1;
    grow      = g;
    model_tick(d, g);
    @(negedge clk);
    tick = 1'b0;
    grow = 1'b0;
    @(negedge clk);
  endtask

  task automatic grow_only();
    @(negedge clk);
    grow = 1'b1;
    m_pend = 1'b1;
    @(negedge clk);
    grow = 1'b0;
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check_status("rst");
    probe(300, 300, "rst_in");
    probe(325, 300, "rst_next");

    // Rightward run, one tick carrying an invalid code, then wrap at the edge.
    for (int i = 0; i < 12; i++) step((i == 5) ? 6 : 3, 1'b0);
    check_head("run12");
    step(3, 1'b0);
    check_head("wrap");

    do_restart();
    step(3, 1'b1);
    check_status("grow1");
    grow_only();
    check_status("grow_pend");
    step(3, 1'b0);
    check_status("grow2");
    probe(300, 300, "old_head");

    step(2, 1'b0);
    check_head("rev_long");
    do_restart();
    step(2, 1'b0);
    check_head("rev_short");

    do_restart();
    for (int i = 0; i < 4; i++) step(3, 1'b1);
    step(0, 1'b0);
    step(0, 1'b0);
    step(2, 1'b0);
    step(1, 1'b0);
    check_status("loop_pre");
    step(3, 1'b0);
    check_status("loop_hit");
    check_head("hit");
    step(3, 1'b0);
    check_head("frozen");
    check_status("frozen");
    do_restart();
    check_status("restart");
    check_head("restart");

    for (int i = 0; i < 10; i++) step(3, 1'b1);
    check_status("sat");
    grow_only();

    // Asynchronous reset while the clock is low and no edge is due.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    x_pos = 10'd300;
    y_pos = 10'd300;
    sb_push("async_len", 1);
    sb_push("async_coll", 0);
    sb_push("async_rgb", 2);
    sb_push("async_head", 1);
    sb_push("async_body", 0);
    #1;
    sb_pop(length);
    sb_pop(collision);
    sb_pop(rgb);
    sb_pop(snake_head_active);
    sb_pop(snake_body_active);
    @(negedge clk);
    rst_n = 1'b1;
    step(3, 1'b0);
    check_status("post_rst");
    check_head("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
